// File: rtl/weight_scheduler.sv
`default_nettype none
// ==========================================================================
// weight_scheduler: streams cfg_len SRAM words from cfg_base, cfg_passes times,
// to the PE array through a 2-entry skid FIFO. Option: WSCHED_PERF_EN (stall_cnt_o).
// Revision: 1.0
// ==========================================================================
module weight_scheduler #(
  parameter int SRAM_DEPTH = 16,
  parameter int K_CHANNELS = 4,
  parameter int INT_WIDTH  = 8,
  parameter int ADDR_W     = $clog2(SRAM_DEPTH),
  parameter int DATA_W     = K_CHANNELS * INT_WIDTH,
  parameter int LEN_W      = ADDR_W + 1,
  parameter int PASS_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_sync_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] cfg_base_i,
  input  logic [LEN_W-1:0]  cfg_len_i,
  input  logic [PASS_W-1:0] cfg_passes_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic [DATA_W-1:0] w_data_o,
  output logic              w_last_o
`ifdef WSCHED_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  word_idx_q;
  logic [PASS_W-1:0] passes_q;
  logic [PASS_W-1:0] pass_idx_q;
  logic              rdv_q;
  logic              rdv_last_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic              fifo_last_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              busy_q;
  logic              done_q;
`ifdef WSCHED_PERF_EN
  logic [31:0]       stall_cnt_q;
`endif

  logic       push;
  logic       pop;
  logic       issue;
  logic       last_word;
  logic       last_pass;
  logic [2:0] occ_d;

  assign push      = rdv_q;
  assign pop       = (count_q != 2'd0) && w_ready_i;
  // Occupancy after this cycle's pop plus the word already in flight; the
  // pop credit is what lets a 2-entry FIFO sustain one word per cycle.
  assign occ_d     = {1'b0, count_q} + {2'b00, rdv_q} - {2'b00, pop};
  assign issue     = (state_q == RUN) && (occ_d < 3'd2);
  assign last_word = (word_idx_q == len_q - LEN_W'(1));
  assign last_pass = (pass_idx_q == passes_q - PASS_W'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_sync_n_i) begin
      state_q        <= IDLE;
      base_q         <= '0;
      len_q          <= '0;
      word_idx_q     <= '0;
      passes_q       <= '0;
      pass_idx_q     <= '0;
      rdv_q          <= 1'b0;
      rdv_last_q     <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef WSCHED_PERF_EN
      stall_cnt_q    <= '0;
`endif
    end else begin
      done_q     <= 1'b0;
      rdv_q      <= issue;
      rdv_last_q <= issue && last_word;

      if (issue) begin
        if (last_word) begin
          word_idx_q <= '0;
          pass_idx_q <= pass_idx_q + PASS_W'(1);
        end else begin
          word_idx_q <= word_idx_q + LEN_W'(1);
        end
      end

      if (push) begin
        fifo_data_q[wr_ptr_q] <= rd_data_i;
        fifo_last_q[wr_ptr_q] <= rdv_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};

`ifdef WSCHED_PERF_EN
      if (state_q == IDLE && start_i) begin
        stall_cnt_q <= '0;
      end else if (count_q != 2'd0 && !w_ready_i && stall_cnt_q != '1) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
`endif

      case (state_q)
        IDLE: begin
          if (start_i) begin
            base_q     <= cfg_base_i;
            len_q      <= cfg_len_i;
            passes_q   <= cfg_passes_i;
            word_idx_q <= '0;
            pass_idx_q <= '0;
            busy_q     <= 1'b1;
            if (cfg_len_i == '0 || cfg_passes_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (issue && last_word && last_pass) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!rdv_q && count_q == 2'd1 && pop) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_en_o   = issue;
  assign rd_addr_o = base_q + word_idx_q[ADDR_W-1:0];
  assign w_valid_o = (count_q != 2'd0);
  assign w_data_o  = fifo_data_q[rd_ptr_q];
  assign w_last_o  = fifo_last_q[rd_ptr_q];
`ifdef WSCHED_PERF_EN
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_weight_scheduler.sv
`default_nettype none
// tb_weight_scheduler: scoreboard bench for weight_scheduler with a 1-cycle SRAM model.
module tb_weight_scheduler;
  localparam int SRAM_DEPTH = 16;
  localparam int K_CHANNELS = 4;
  localparam int INT_WIDTH  = 8;
  localparam int ADDR_W     = 4;
  localparam int DATA_W     = 32;
  localparam int LEN_W      = 5;
  localparam int PASS_W     = 16;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } exp_t;

  logic              clk;
  logic              rst_sync_n_i;
  logic              start_i;
  logic [ADDR_W-1:0] cfg_base_i;
  logic [LEN_W-1:0]  cfg_len_i;
  logic [PASS_W-1:0] cfg_passes_i;
  logic              busy_o;
  logic              done_o;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_i;
  logic              w_valid_o;
  logic              w_ready_i;
  logic [DATA_W-1:0] w_data_o;
  logic              w_last_o;
`ifdef WSCHED_PERF_EN
  logic [31:0]       stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int rd_cnt;
  int first_rd_cyc;
  int first_valid_cyc;
  exp_t              exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  weight_scheduler #(
    .SRAM_DEPTH(SRAM_DEPTH),
    .K_CHANNELS(K_CHANNELS),
    .INT_WIDTH (INT_WIDTH),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LEN_W     (LEN_W),
    .PASS_W    (PASS_W)
  ) dut (
    .clk_i       (clk),
    .rst_sync_n_i(rst_sync_n_i),
    .start_i     (start_i),
    .cfg_base_i  (cfg_base_i),
    .cfg_len_i   (cfg_len_i),
    .cfg_passes_i(cfg_passes_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .rd_data_i   (rd_data_i),
    .w_valid_o   (w_valid_o),
    .w_ready_i   (w_ready_i),
    .w_data_o    (w_data_o),
    .w_last_o    (w_last_o)
`ifdef WSCHED_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] data_of(input logic [ADDR_W-1:0] a);
    return {8'hA5, 4'h0, a, 4'h5, ~a, 4'hC, a ^ 4'h9};
  endfunction

  // SRAM model: read data valid the cycle after rd_en_o
  always @(posedge clk) begin
    if (rd_en_o) rd_data_i <= data_of(rd_addr_o);
  end

  task automatic do_start(input logic [ADDR_W-1:0] base, input int len, input int passes);
    exp_t e;
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    cfg_base_i   = base;
    cfg_len_i    = LEN_W'(len);
    cfg_passes_i = PASS_W'(passes);
    start_i      = 1'b1;
    for (int p = 0; p < passes; p++) begin
      for (int w = 0; w < len; w++) begin
        a = base + ADDR_W'(w);
        addr_q.push_back(a);
        e.data = data_of(a);
        e.last = (w == len - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // mode 0: ready always; 1: ready on odd cycles; 2: hold ready low for 5 stall cycles
  task automatic run_stream(input int mode, input int max_cycles);
    int cyc, stalls;
    bit last_hs, got_done, holding;
    logic [DATA_W-1:0] held;
    logic [ADDR_W-1:0] a;
    exp_t e;
    cyc = 0; stalls = 0; last_hs = 0; got_done = 0; holding = 0; held = '0;
    rd_cnt = 0; first_rd_cyc = -1; first_valid_cyc = -1;
    while (!got_done && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
      start_i      = 1'b0;
      cfg_base_i   = 4'hB;
      cfg_len_i    = 5'd1;
      cfg_passes_i = 16'd1;
      if (cyc == 4 && busy_o) start_i = 1'b1;
      if (cyc == 1) begin
        checks++;
        if (busy_o !== 1'b1) begin
          errors++;
          $display("FAIL busy_after_start: busy=%0b, required 1", busy_o);
        end
      end
      if (last_hs) begin
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
          errors++;
          $display("FAIL done_pulse: done=%0b busy=%0b, required done=1 busy=0", done_o, busy_o);
        end
        got_done = 1;
        break;
      end else if (done_o === 1'b1) begin
        checks++; errors++;
        $display("FAIL early_done: done=1 at cycle %0d with %0d words pending, required 0", cyc, exp_q.size());
      end
      if (holding) begin
        checks++;
        if (w_valid_o !== 1'b1 || w_data_o !== held) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b data=%h, required valid=1 data=%h", w_valid_o, w_data_o, held);
        end
      end
      case (mode)
        1:       w_ready_i = (cyc % 2) == 1;
        2:       w_ready_i = (stalls >= 5);
        default: w_ready_i = 1'b1;
      endcase
      #1;
      if (rd_en_o) begin
        rd_cnt++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL extra_read: rd_addr=%0d, required no read", rd_addr_o);
        end else begin
          a = addr_q.pop_front();
          if (rd_addr_o !== a) begin
            errors++;
            $display("FAIL rd_addr: got %0d, required %0d", rd_addr_o, a);
          end
        end
      end
      if (w_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (w_valid_o && !w_ready_i) stalls++;
      holding = w_valid_o && !w_ready_i;
      held    = w_data_o;
      if (w_valid_o && w_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_word: data=%h, required no word", w_data_o);
        end else begin
          e = exp_q.pop_front();
          if (w_data_o !== e.data || w_last_o !== e.last) begin
            errors++;
            $display("FAIL word: data=%h last=%0b, required data=%h last=%0b", w_data_o, w_last_o, e.data, e.last);
          end
          if (exp_q.size() == 0) last_hs = 1;
        end
      end
    end
    if (!got_done) begin
      checks++; errors++;
      $display("FAIL timeout: %0d words outstanding after %0d cycles, required done", exp_q.size(), cyc);
    end
    w_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_sync_n_i = 1'b0;
    start_i = 1'b0; w_ready_i = 1'b0;
    cfg_base_i = '0; cfg_len_i = '0; cfg_passes_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, done_o, rd_en_o, w_valid_o, w_last_o, rd_addr_o, w_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b done=%0b rd_en=%0b valid=%0b last=%0b addr=%0d data=%h, required all 0",
               busy_o, done_o, rd_en_o, w_valid_o, w_last_o, rd_addr_o, w_data_o);
    end
    rst_sync_n_i = 1'b1;
  endtask

  task automatic test_basic();
    do_start(4'd4, 3, 2);
    run_stream(0, 60);
    checks++;
    if (first_rd_cyc != 1 || first_valid_cyc != 3) begin
      errors++;
      $display("FAIL latency: rd_en at %0d valid at %0d, required 1 and 3", first_rd_cyc, first_valid_cyc);
    end
    checks++;
    if (rd_cnt != 6) begin
      errors++;
      $display("FAIL basic_reads: got %0d reads, required 6", rd_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_start(4'd0, 8, 1);
    run_stream(1, 100);
    checks++;
    if (rd_cnt != 8) begin
      errors++;
      $display("FAIL bp_reads: got %0d reads, required 8", rd_cnt);
    end
  endtask

  task automatic test_wrap();
    do_start(4'(SRAM_DEPTH - 2), 4, 1);
    run_stream(0, 60);
    checks++;
    if (addr_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_reads: %0d addresses never read, required 0", addr_q.size());
    end
  endtask

  task automatic test_zero_work();
    int rds;
    do_start(4'd3, 0, 5);
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b1 || rd_en_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_first: busy=%0b done=%0b rd_en=%0b, required 1 1 0", busy_o, done_o, rd_en_o);
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_second: busy=%0b done=%0b, required 0 0", busy_o, done_o);
    end
    rds = 0;
    for (int i = 0; i < 4; i++) begin
      if (rd_en_o === 1'b1) rds++;
      @(negedge clk);
    end
    checks++;
    if (rds != 0) begin
      errors++;
      $display("FAIL zero_reads: got %0d reads, required 0", rds);
    end
  endtask

  task automatic test_reset_midrun();
    int hs, cyc;
    do_start(4'd0, 10, 1);
    hs = 0; cyc = 0;
    while (hs < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start_i = 1'b0;
      w_ready_i = 1'b1;
      #1;
      if (w_valid_o) hs++;
    end
    checks++;
    if (hs < 3) begin
      errors++;
      $display("FAIL midrun_progress: got %0d words, required 3", hs);
    end
    @(negedge clk);
    rst_sync_n_i = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, rd_en_o, w_valid_o, w_last_o, rd_addr_o, w_data_o} !== '0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%0b done=%0b rd_en=%0b valid=%0b last=%0b addr=%0d data=%h, required all 0",
               busy_o, done_o, rd_en_o, w_valid_o, w_last_o, rd_addr_o, w_data_o);
    end
    rst_sync_n_i = 1'b1;
    w_ready_i = 1'b0;
    exp_q.delete();
    addr_q.delete();
    do_start(4'd5, 3, 1);
    run_stream(0, 60);
  endtask

`ifdef WSCHED_PERF_EN
  task automatic test_perf();
    do_start(4'd8, 4, 1);
    run_stream(2, 80);
    checks++;
    if (stall_cnt_o !== 32'd5) begin
      errors++;
      $display("FAIL stall_cnt: got %0d, required 5", stall_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_work();
    test_reset_midrun();
`ifdef WSCHED_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
